// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver.
// Frame: 1 start bit (0), DATA_WIDTH data bits LSB first, optional parity bit,
// 1 stop bit (1). CLK runs at OVERSAMPLE cycles per bit.
// Optional build macro UART_RX_MAJORITY_EN: each bit is the 2-of-3 majority of
// the samples just before, at and just after mid-bit, decided one cycle later.
module uart_rx #(
  parameter int OVERSAMPLE = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VALID,
  output logic                  PAR_ERR,
  output logic                  STP_ERR
);

  localparam int EW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [EW-1:0] LAST_EDGE = EW'(OVERSAMPLE - 1);
  localparam logic [EW-1:0] MID_EDGE  = EW'(OVERSAMPLE / 2);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t state, state_next;

  logic                  sync_1;
  logic                  rx_s;
  logic [EW-1:0]         edge_cnt, edge_next;
  logic [BW-1:0]         bit_cnt, bit_next;
  logic [DATA_WIDTH-1:0] shift_reg, shift_next;
  logic                  mismatch, mismatch_next;
  logic                  par_en_r, par_en_next;
  logic                  par_typ_r, par_typ_next;
  logic [DATA_WIDTH-1:0] p_data_next;
  logic                  valid_next, par_err_next, stp_err_next;

  logic                  bit_value;
  logic                  decide;
  logic                  wrap;

  // Two-flop synchronizer; idles high so reset never looks like a start bit
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_1 <= 1'b1;
      rx_s   <= 1'b1;
    end else begin
      sync_1 <= RX_IN;
      rx_s   <= sync_1;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  localparam logic [EW-1:0] EARLY_EDGE  = EW'(OVERSAMPLE / 2 - 1);
  localparam logic [EW-1:0] DECIDE_EDGE = EW'(OVERSAMPLE / 2 + 1);

  logic vote_a, vote_b;

  // Capture the two earlier votes; the third vote is the live rx_s at decide time
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vote_a <= 1'b1;
      vote_b <= 1'b1;
    end else begin
      if (edge_cnt == EARLY_EDGE) vote_a <= rx_s;
      if (edge_cnt == MID_EDGE)   vote_b <= rx_s;
    end
  end

  assign bit_value = (vote_a & vote_b) | (vote_a & rx_s) | (vote_b & rx_s);
  assign decide    = (edge_cnt == DECIDE_EDGE);
`else
  assign bit_value = rx_s;
  assign decide    = (edge_cnt == MID_EDGE);
`endif

  assign wrap = (edge_cnt == LAST_EDGE);

  // Frame state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  // Counters, shift register, latched frame config and output strobes
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      mismatch   <= 1'b0;
      par_en_r   <= 1'b0;
      par_typ_r  <= 1'b0;
      P_DATA     <= '0;
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
    end else begin
      edge_cnt   <= edge_next;
      bit_cnt    <= bit_next;
      shift_reg  <= shift_next;
      mismatch   <= mismatch_next;
      par_en_r   <= par_en_next;
      par_typ_r  <= par_typ_next;
      P_DATA     <= p_data_next;
      DATA_VALID <= valid_next;
      PAR_ERR    <= par_err_next;
      STP_ERR    <= stp_err_next;
    end
  end

  // Next-state and datapath decisions; the stop-bit decision ends the frame
  // immediately so a back-to-back start bit is not missed
  always_comb begin
    state_next    = state;
    edge_next     = edge_cnt;
    bit_next      = bit_cnt;
    shift_next    = shift_reg;
    mismatch_next = mismatch;
    par_en_next   = par_en_r;
    par_typ_next  = par_typ_r;
    p_data_next   = P_DATA;
    valid_next    = 1'b0;
    par_err_next  = 1'b0;
    stp_err_next  = 1'b0;

    if (state != IDLE) begin
      edge_next = wrap ? '0 : edge_cnt + EW'(1);
    end

    case (state)
      IDLE: begin
        edge_next = '0;
        if (!rx_s) begin
          state_next    = START;
          edge_next     = EW'(1);
          bit_next      = '0;
          mismatch_next = 1'b0;
          par_en_next   = PAR_EN;
          par_typ_next  = PAR_TYP;
        end
      end

      START: begin
        if (decide && bit_value) begin
          state_next = IDLE;
          edge_next  = '0;
        end else if (wrap) begin
          state_next = DATA;
          bit_next   = '0;
        end
      end

      DATA: begin
        if (decide) begin
          shift_next = {bit_value, shift_reg[DATA_WIDTH-1:1]};
        end
        if (wrap) begin
          if (bit_cnt == LAST_BIT) begin
            state_next = par_en_r ? PARITY : STOP;
            bit_next   = '0;
          end else begin
            bit_next = bit_cnt + BW'(1);
          end
        end
      end

      PARITY: begin
        if (decide) begin
          mismatch_next = (bit_value != ((^shift_reg) ^ par_typ_r));
        end
        if (wrap) begin
          state_next = STOP;
        end
      end

      STOP: begin
        if (decide) begin
          state_next   = IDLE;
          edge_next    = '0;
          par_err_next = mismatch;
          stp_err_next = !bit_value;
          if (bit_value && !mismatch) begin
            p_data_next = shift_reg;
            valid_next  = 1'b1;
          end
        end
      end

      default: begin
        state_next = IDLE;
        edge_next  = '0;
      end
    endcase
  end

endmodule
